axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter: NUM_WORDS, default 1024; depth of backing store in 64-bit words, power of two, at least 16.
REQ-002 Parameter: ID_WIDTH, default 4; width of the AXI ID field.
REQ-003 Port: clk_i  input  1  clock; all logic is on the rising edge.
REQ-004 Port: rst_ni  input  1  reset, synchronous and active-low.
REQ-005 Port: axi_req_i  input  ariane_axi::req_t  AXI request channels (AW, W, AR), valids and b_ready/r_ready.
REQ-006 Port: axi_resp_o  output  ariane_axi::resp_t  AXI response channels (R, B), readys and valids.
REQ-007 Port: busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-008 The block SHALL be an AXI4 subordinate serving cache-line refills and write-backs from the dcache miss handler, with one outstanding transaction.
REQ-009 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_DATA and WR_RESP.
REQ-010 In IDLE, aw_ready SHALL be 1; ar_ready SHALL be 1 only when aw_valid=0, so AW has priority over a simultaneous AR.
REQ-011 On an AW handshake, the block SHALL latch id, addr, len and burst, then go to WR_DATA. On an AR handshake, it SHALL latch the same fields and go to RD_ADDR.
REQ-012 Word index SHALL be addr[3 +: log2(NUM_WORDS)]. Higher address bits SHALL be ignored (aliasing). Index increments SHALL wrap modulo NUM_WORDS.
REQ-013 Only burst=INCR and size=3 SHALL be serviced. Any other burst or size SHALL perform no storage access and return SLVERR on every beat (read) or on B (write).
REQ-014 RD_ADDR: the block SHALL issue a single-cycle storage read at the current index and go to RD_DATA on the next cycle.
REQ-015 RD_DATA: r_valid=1 with r_data = storage word, r_id = latched id, r_resp = OKAY and r_last = (beat count == len). All R fields SHALL be stable until r_ready.
REQ-016 On an R handshake with r_last=0, the block SHALL increment index and beat count and return to RD_ADDR. With r_last=1 it SHALL return to IDLE. Read throughput is one beat per two cycles.
REQ-017 WR_DATA: w_ready SHALL be 1. Each W handshake SHALL write w_data into the current word under w_strb byte masks in the same cycle, then increment the index.
REQ-018 A write burst SHALL end on the beat carrying w_last, moving to WR_RESP.
- A w_last beat count different from len+1 SHALL set b_resp=SLVERR.
- Data beats beyond len+1 before w_last SHALL be discarded, not written.
REQ-019 WR_RESP: b_valid=1, b_id = latched id and b_resp as determined. On b_ready the block SHALL return to IDLE.
REQ-020 A read issued immediately after a write to the same word SHALL return the newly written data.
REQ-021 All readys and valids not named as asserted in the current state SHALL be 0. The block SHALL never assert r_valid and b_valid together.
REQ-022 The beat counter SHALL be 8 bits wide so that len=255 completes without overflow.

Reset
REQ-023 While rst_ni=0 at a clock edge, the FSM SHALL enter IDLE, and beat count, index and latched fields SHALL clear to 0.
REQ-024 Reset values: aw_ready/w_ready/ar_ready 0 during reset, b_valid 0, r_valid 0, r_last 0, busy_o 0, all data/id/resp outputs 0.
REQ-025 Storage contents SHALL NOT be reset.
REQ-026 Reset asserted mid-burst SHALL abandon the transaction with no further beats or response. Words already written SHALL persist.

Verification
REQ-027 Write-then-read line:
- AW addr=0x80, len=1, id=3; W beats 0x1111, 0x2222 (strb=0xFF, last on 2nd) -> b_valid with id=3, OKAY.
- AR addr=0x80, len=1 -> R 0x1111 (last=0), then 0x2222 (last=1), id=3, OKAY.
REQ-028 Byte strobe: word holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with strb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
REQ-029 Simultaneous AW and AR valid in IDLE -> AW accepted first, ar_ready=0 that cycle; the read is accepted after B completes.
REQ-030 Backpressure and wrap:
- r_ready held 0 for 5 cycles -> r_data/r_last stable throughout.
- INCR burst starting at the last word (index NUM_WORDS-1), len=1 -> second beat reads index 0.
REQ-031 Errors:
- AW len=3 with w_last on the 2nd beat -> b_resp=SLVERR, state IDLE afterwards.
- AR burst=WRAP, len=1 -> two beats with SLVERR, no storage access.
REQ-032 Reset mid-burst: rst_ni=0 during RD_DATA of a len=3 read -> next cycle r_valid=0, busy_o=0; a new AR is accepted normally after reset release.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 memory subordinate for dcache line refills and write-backs.
// Serves one transaction at a time from a 64-bit word store.

package ariane_axi;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_mem_responder #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned ID_WIDTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o,
    output logic              busy_o
);
    localparam int unsigned IdxW     = $clog2(NUM_WORDS);
    localparam int unsigned BeatW    = 8;
    localparam int unsigned DataW    = ariane_axi::DataWidth;
    localparam int unsigned NumBytes = DataW / 8;
    localparam int unsigned IdW      = ariane_axi::IdWidth;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    state_t              r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [IdxW-1:0]     r_idx;
    logic [7:0]          r_len;
    logic [BeatW-1:0]    r_beat;
    logic                r_ok;       // latched burst/size is serviceable
    logic                r_extra;    // write beats past len+1 have arrived
    logic                r_addr_rdy;
    logic                r_w_ready;
    logic                r_b_valid;
    logic [1:0]          r_b_resp;
    logic                r_r_valid;
    logic                r_r_last;
    logic [1:0]          r_r_resp;
    logic [DataW-1:0]    r_r_data;
    logic                r_busy;
    logic [DataW-1:0]    r_mem [NUM_WORDS];

    logic w_aw_hs;
    logic w_ar_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_b_hs;
    logic w_we;
    logic w_aw_ok;
    logic w_ar_ok;
    logic w_unused;

    // Handshake decode; AW wins over a simultaneous AR
    assign w_aw_hs = (r_state == S_IDLE) && r_addr_rdy && axi_req_i.aw_valid;
    assign w_ar_hs = (r_state == S_IDLE) && r_addr_rdy && !axi_req_i.aw_valid
                     && axi_req_i.ar_valid;
    assign w_w_hs  = (r_state == S_WR_DATA) && r_w_ready && axi_req_i.w_valid;
    assign w_r_hs  = r_r_valid && axi_req_i.r_ready;
    assign w_b_hs  = r_b_valid && axi_req_i.b_ready;
    assign w_aw_ok = (axi_req_i.aw.burst == ariane_axi::BURST_INCR) && (axi_req_i.aw.size == 3'd3);
    assign w_ar_ok = (axi_req_i.ar.burst == ariane_axi::BURST_INCR) && (axi_req_i.ar.size == 3'd3);
    assign w_we    = rst_ni && w_w_hs && r_ok && !r_extra;
    assign w_unused = ^axi_req_i;

    // Transaction FSM with registered channel outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_id       <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_ok       <= 1'b0;
            r_extra    <= 1'b0;
            r_addr_rdy <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= '0;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_r_resp   <= '0;
            r_r_data   <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr_rdy <= 1'b1;
                    if (w_aw_hs) begin
                        r_id       <= ID_WIDTH'(axi_req_i.aw.id);
                        r_idx      <= axi_req_i.aw.addr[3 +: IdxW];
                        r_len      <= axi_req_i.aw.len;
                        r_ok       <= w_aw_ok;
                        r_beat     <= '0;
                        r_extra    <= 1'b0;
                        r_addr_rdy <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WR_DATA;
                    end else if (w_ar_hs) begin
                        r_id       <= ID_WIDTH'(axi_req_i.ar.id);
                        r_idx      <= axi_req_i.ar.addr[3 +: IdxW];
                        r_len      <= axi_req_i.ar.len;
                        r_ok       <= w_ar_ok;
                        r_beat     <= '0;
                        r_extra    <= 1'b0;
                        r_addr_rdy <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    r_r_data  <= r_ok ? r_mem[r_idx] : '0;
                    r_r_resp  <= r_ok ? ariane_axi::RESP_OKAY : ariane_axi::RESP_SLVERR;
                    r_r_last  <= (r_beat == r_len);
                    r_r_valid <= 1'b1;
                    r_state   <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_r_valid <= 1'b0;
                        if (r_r_last) begin
                            r_addr_rdy <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_beat  <= r_beat + BeatW'(1);
                            r_idx   <= r_idx + IdxW'(1);
                            r_state <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_w_hs) begin
                        if (w_we) begin
                            r_idx <= r_idx + IdxW'(1);
                        end
                        if (axi_req_i.w.last) begin
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            r_b_resp  <= (r_ok && !r_extra && (r_beat == r_len))
                                         ? ariane_axi::RESP_OKAY : ariane_axi::RESP_SLVERR;
                            r_state   <= S_WR_RESP;
                        end else if (r_beat == r_len) begin
                            r_extra <= 1'b1;
                        end else begin
                            r_beat <= r_beat + BeatW'(1);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_b_valid  <= 1'b0;
                        r_addr_rdy <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-masked storage write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (axi_req_i.w.strb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
                end
            end
        end
    end

    // Response packing; ar_ready yields to a concurrent aw_valid
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = r_addr_rdy;
        axi_resp_o.ar_ready = r_addr_rdy & ~axi_req_i.aw_valid;
        axi_resp_o.w_ready  = r_w_ready;
        axi_resp_o.b_valid  = r_b_valid;
        axi_resp_o.b.id     = IdW'(r_id);
        axi_resp_o.b.resp   = r_b_resp;
        axi_resp_o.r_valid  = r_r_valid;
        axi_resp_o.r.id     = IdW'(r_id);
        axi_resp_o.r.data   = r_r_data;
        axi_resp_o.r.resp   = r_r_resp;
        axi_resp_o.r.last   = r_r_last;
    end

    assign busy_o = r_busy;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array memory model.

module tb_axi_mem_responder;
    localparam int unsigned NW = 16;

    logic              clk;
    logic              rst_n;
    logic              busy;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [63:0] model [NW];
    logic [63:0] wd [32];
    logic [7:0]  ws [32];

    logic [3:0]  c_id;
    int          c_idx;
    int          c_len;
    bit          c_ok;
    logic [1:0]  c_bresp;

    axi_mem_responder #(.NUM_WORDS(NW), .ID_WIDTH(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctx(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        c_id  = id;
        c_idx = int'((a >> 3) % 64'(NW));
        c_len = int'(len);
        c_ok  = (burst == 2'b01) && (size == 3'd3);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int  to = 0;
        bit  hs;
        set_ctx(id, a, len, size, burst);
        req.aw.id = id; req.aw.addr = a; req.aw.len = len;
        req.aw.size = size; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        forever begin
            #2; hs = resp.aw_ready;
            step();
            if (hs) break;
            to++;
            if (to > 100) begin chk("aw_timeout", 0, 1); break; end
        end
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int  to = 0;
        bit  hs;
        set_ctx(id, a, len, size, burst);
        req.ar.id = id; req.ar.addr = a; req.ar.len = len;
        req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        forever begin
            #2; hs = resp.ar_ready;
            step();
            if (hs) break;
            to++;
            if (to > 100) begin chk("ar_timeout", 0, 1); break; end
        end
        req.ar_valid = 1'b0;
    endtask

    // Sends nb beats and applies the model: only beats 0..len of a good burst land
    task automatic send_w(input int nb);
        logic [63:0] m;
        int          w;
        for (int k = 0; k < nb; k++) begin
            int to = 0;
            bit hs;
            req.w_valid = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            req.w.data = wd[k]; req.w.strb = ws[k]; req.w.last = (k == nb - 1);
            req.w_valid = 1'b1;
            forever begin
                #2; hs = resp.w_ready;
                step();
                if (hs) break;
                to++;
                if (to > 100) begin chk("w_timeout", 0, 1); break; end
            end
            if (c_ok && k <= c_len) begin
                w = (c_idx + k) % NW;
                m = model[w];
                for (int b = 0; b < 8; b++)
                    if (ws[k][b]) m[8*b +: 8] = wd[k][8*b +: 8];
                model[w] = m;
            end
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        c_bresp = (c_ok && nb == c_len + 1) ? 2'b00 : 2'b10;
    endtask

    task automatic recv_b();
        int to = 0;
        while (!resp.b_valid && to < 50) begin step(); to++; end
        chk("b_valid", resp.b_valid, 1);
        chk("b_id", resp.b.id, c_id);
        chk("b_resp", resp.b.resp, c_bresp);
        chk("br_excl", resp.r_valid, 0);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("b_hold", resp.b_valid, 1);
        end
        req.b_ready = 1'b1;
        step();
        req.b_ready = 1'b0;
        chk("b_busy_end", busy, 0);
    endtask

    task automatic recv_r(input int hold);
        for (int k = 0; k <= c_len; k++) begin
            int          to = 0;
            int          h;
            logic [63:0] ed;
            logic [1:0]  er;
            while (!resp.r_valid && to < 50) begin step(); to++; end
            chk("r_valid", resp.r_valid, 1);
            ed = model[(c_idx + k) % NW];
            er = c_ok ? 2'b00 : 2'b10;
            chk("r_id", resp.r.id, c_id);
            chk("r_resp", resp.r.resp, er);
            chk("r_last", resp.r.last, (k == c_len));
            if (c_ok) chk("r_data", resp.r.data, ed);
            chk("rb_excl", resp.b_valid, 0);
            h = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
            repeat (h) begin
                step();
                chk("r_hold_valid", resp.r_valid, 1);
                chk("r_hold_last", resp.r.last, (k == c_len));
                if (c_ok) chk("r_hold_data", resp.r.data, ed);
            end
            req.r_ready = 1'b1;
            step();
            req.r_ready = 1'b0;
        end
        chk("r_busy_end", busy, 0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nb);
        send_aw(id, a, len, size, burst);
        send_w(nb);
        recv_b();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold);
        send_ar(id, a, len, size, burst);
        recv_r(hold);
    endtask

    initial begin
        req   = '0;
        rst_n = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_aw_ready", resp.aw_ready, 0);
        chk("rst_ar_ready", resp.ar_ready, 0);
        chk("rst_w_ready", resp.w_ready, 0);
        chk("rst_b_valid", resp.b_valid, 0);
        chk("rst_r_valid", resp.r_valid, 0);
        chk("rst_r_last", resp.r.last, 0);
        chk("rst_r_data", resp.r.data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Fill the whole store so the model is fully known
        for (int k = 0; k < 16; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = 8'hFF;
        end
        do_write(4'd1, 64'h0, 8'd15, 3'd3, 2'b01, 16);
        do_read(4'd2, 64'h0, 8'd15, 3'd3, 2'b01, -1);

        // Write-then-read line (0x80 aliases to word 0 with 16 words)
        wd[0] = 64'h1111; wd[1] = 64'h2222; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd3, 64'h80, 8'd1, 3'd3, 2'b01, 2);
        chk("wr_line_bresp", c_bresp, 0);
        do_read(4'd3, 64'h80, 8'd1, 3'd3, 2'b01, 0);

        // Byte strobe merge
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(4'd4, 64'h28, 8'd0, 3'd3, 2'b01, 1);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        do_write(4'd4, 64'h28, 8'd0, 3'd3, 2'b01, 1);
        chk("strb_model", model[5], 64'hFFFF_FFFF_0000_0000);
        do_read(4'd4, 64'h28, 8'd0, 3'd3, 2'b01, 0);

        // Simultaneous AW and AR: AW first, AR after B
        req.aw.id = 4'd5; req.aw.addr = 64'h10; req.aw.len = 8'd1;
        req.aw.size = 3'd3; req.aw.burst = 2'b01;
        req.ar.id = 4'd6; req.ar.addr = 64'h10; req.ar.len = 8'd1;
        req.ar.size = 3'd3; req.ar.burst = 2'b01;
        req.aw_valid = 1'b1; req.ar_valid = 1'b1;
        #2;
        chk("sim_aw_ready", resp.aw_ready, 1);
        chk("sim_ar_ready", resp.ar_ready, 0);
        step();
        req.aw_valid = 1'b0;
        set_ctx(4'd5, 64'h10, 8'd1, 3'd3, 2'b01);
        wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom};
        ws[0] = 8'hFF; ws[1] = 8'hA5;
        send_w(2);
        chk("sim_ar_blocked", resp.ar_ready, 0);
        recv_b();
        send_ar(4'd6, 64'h10, 8'd1, 3'd3, 2'b01);
        recv_r(-1);

        // Backpressure: r_ready low for 5 cycles
        do_read(4'd7, 64'h38, 8'd1, 3'd3, 2'b01, 5);

        // Wrap from the last word back to word 0
        do_read(4'd8, 64'h78, 8'd1, 3'd3, 2'b01, 1);

        // Early w_last: len=3, last on beat 2
        wd[0] = 64'hAAAA; wd[1] = 64'hBBBB; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd9, 64'h40, 8'd3, 3'd3, 2'b01, 2);
        chk("early_last_bresp", c_bresp, 2);

        // Late w_last: extra beats discarded
        wd[0] = 64'hC0C0; wd[1] = 64'hD1D1; wd[2] = 64'hE2E2;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
        do_write(4'd10, 64'h48, 8'd0, 3'd3, 2'b01, 3);
        do_read(4'd10, 64'h48, 8'd1, 3'd3, 2'b01, 0);

        // Bad burst/size: no storage access, SLVERR
        do_read(4'd11, 64'h8, 8'd1, 3'd3, 2'b10, 0);
        wd[0] = 64'h5555; ws[0] = 8'hFF;
        do_write(4'd12, 64'h8, 8'd0, 3'd2, 2'b01, 1);
        do_read(4'd12, 64'h8, 8'd0, 3'd3, 2'b01, 0);

        // Reset mid-burst during RD_DATA
        send_ar(4'd13, 64'h20, 8'd3, 3'd3, 2'b01);
        begin
            int to = 0;
            while (!resp.r_valid && to < 50) begin step(); to++; end
            chk("mid_rvalid", resp.r_valid, 1);
        end
        rst_n = 1'b0;
        step();
        chk("mid_rst_rvalid", resp.r_valid, 0);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        do_read(4'd14, 64'h20, 8'd1, 3'd3, 2'b01, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [63:0] a;
            logic [7:0]  len;
            logic [1:0]  burst;
            logic [2:0]  size;
            int          r;
            int          nb;
            a = {$urandom, $urandom};
            a[2:0] = 3'b000;
            len = 8'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            burst = (r == 0) ? 2'b10 : 2'b01;
            size  = (r == 1) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 1) begin
                nb = int'(len) + 1;
                if ($urandom_range(0, 5) == 0) nb = int'($urandom_range(1, int'(len) + 3));
                for (int k = 0; k < nb; k++) begin
                    wd[k] = {$urandom, $urandom};
                    ws[k] = 8'($urandom);
                end
                do_write(4'($urandom), a, len, size, burst, nb);
            end else begin
                do_read(4'($urandom), a, len, size, burst, -1);
            end
        end

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
